// File: rtl/adder_pipe.sv
// adder_pipe: valid/ready adder whose carry chain is cut into STAGES registered slices.
// Optional macro ADDER_PIPE_SAT_EN adds input 'sat' that clamps sum to all-ones on carry out.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADDER_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [15:0]      ovf_cnt
);

    localparam int SLICE = WIDTH / STAGES;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("adder_pipe: WIDTH=%0d outside legal range 2..64", WIDTH);
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("adder_pipe: STAGES=%0d outside legal range 1..8", STAGES);
    end
    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("adder_pipe: WIDTH=%0d not divisible by STAGES=%0d", WIDTH, STAGES);
    end

    // One global advance: the whole pipe shifts or the whole pipe holds.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE;             // sum bits already resolved upstream
        localparam int REM = WIDTH - LO - SLICE;    // operand bits still to be added after this stage

        logic [WIDTH-LO-1:0] a_hi, b_hi;
        logic                c_in, v_in;
        logic [SLICE:0]      slice_sum;
        logic [LO+SLICE-1:0] s_d, s_q;
        logic                v_q, c_q;
`ifdef ADDER_PIPE_SAT_EN
        logic                sat_in, sat_q;
`endif

        if (k == 0) begin : g_src
            assign a_hi = a;
            assign b_hi = b;
            assign c_in = ci;
            assign v_in = in_valid;
            assign s_d  = slice_sum[SLICE-1:0];
`ifdef ADDER_PIPE_SAT_EN
            assign sat_in = sat;
`endif
        end else begin : g_src
            assign a_hi = g_stage[k-1].g_rem.a_q;
            assign b_hi = g_stage[k-1].g_rem.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_d  = {slice_sum[SLICE-1:0], g_stage[k-1].s_q};
`ifdef ADDER_PIPE_SAT_EN
            assign sat_in = g_stage[k-1].sat_q;
`endif
        end

        assign slice_sum = {1'b0, a_hi[SLICE-1:0]} + {1'b0, b_hi[SLICE-1:0]}
                         + {{SLICE{1'b0}}, c_in};

        // NOTE: data registers are reset along with the valid bits so sum/co read 0 after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
`ifdef ADDER_PIPE_SAT_EN
                sat_q <= 1'b0;
`endif
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= slice_sum[SLICE];
                s_q   <= s_d;
`ifdef ADDER_PIPE_SAT_EN
                sat_q <= sat_in;
`endif
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_q, b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_hi[WIDTH-LO-1:SLICE];
                    b_q <= b_hi[WIDTH-LO-1:SLICE];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign co        = g_stage[STAGES-1].c_q;
`ifdef ADDER_PIPE_SAT_EN
    assign sum = (g_stage[STAGES-1].sat_q && g_stage[STAGES-1].c_q)
               ? {WIDTH{1'b1}} : g_stage[STAGES-1].s_q;
`else
    assign sum = g_stage[STAGES-1].s_q;
`endif

    // Counts raw carries on output transfers, even when the sum was clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= 16'h0000;
        end else if (out_valid && out_ready && co && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed self-checking bench for adder_pipe, one 4-bit/2-stage and one
// 8-bit/4-stage instance; the saturation test is built only with ADDER_PIPE_SAT_EN.
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic v4, r4, ov4, ordy4, ci4, co4;
    logic [3:0] a4, b4, s4;
    logic [15:0] cnt4;
    logic v8, r8, ov8, ordy8, ci8, co8;
    logic [7:0] a8, b8, s8;
    logic [15:0] cnt8;
`ifdef ADDER_PIPE_SAT_EN
    logic sat4 = 1'b0;
    logic sat8 = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    adder_pipe #(.WIDTH(4), .STAGES(2)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4), .ci(ci4),
`ifdef ADDER_PIPE_SAT_EN
        .sat(sat4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .sum(s4), .co(co4), .ovf_cnt(cnt4)
    );

    adder_pipe #(.WIDTH(8), .STAGES(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8), .ci(ci8),
`ifdef ADDER_PIPE_SAT_EN
        .sat(sat8),
`endif
        .out_valid(ov8), .out_ready(ordy8), .sum(s8), .co(co8), .ovf_cnt(cnt8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single accepted push on u8; caller guarantees the pipe is advancing.
    task automatic put8(input logic [7:0] a_v, input logic [7:0] b_v, input logic ci_v);
        a8 = a_v; b8 = b_v; ci8 = ci_v; v8 = 1'b1;
        step();
        v8 = 1'b0;
    endtask

    task automatic get8(output logic [7:0] s_v, output logic c_v, output bit ok);
        ordy8 = 1'b1;
        ok = 1'b0;
        s_v = '0;
        c_v = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ov8) begin
                s_v = s8; c_v = co8; ok = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        {v4, ordy4, ci4, v8, ordy8, ci8} = '0;
        {a4, b4} = '0;
        {a8, b8} = '0;
        #1 rst_n = 1'b0;
        #3;
        n_tests++; if (ov4 !== 1'b0)    begin n_fail++; $display("FAIL rst_ov4: got %b want 0", ov4); end
        n_tests++; if (s4 !== 4'h0)     begin n_fail++; $display("FAIL rst_sum4: got %h want 0", s4); end
        n_tests++; if (co4 !== 1'b0)    begin n_fail++; $display("FAIL rst_co4: got %b want 0", co4); end
        n_tests++; if (cnt4 !== 16'h0)  begin n_fail++; $display("FAIL rst_cnt4: got %h want 0", cnt4); end
        n_tests++; if (r4 !== 1'b1)     begin n_fail++; $display("FAIL rst_rdy4: got %b want 1", r4); end
        n_tests++; if (ov8 !== 1'b0)    begin n_fail++; $display("FAIL rst_ov8: got %b want 0", ov8); end
        n_tests++; if (cnt8 !== 16'h0)  begin n_fail++; $display("FAIL rst_cnt8: got %h want 0", cnt8); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        n_tests++; if (r8 !== 1'b1)     begin n_fail++; $display("FAIL post_rst_rdy8: got %b want 1", r8); end
    endtask

    task automatic test_latency();
        a4 = 4'hA; b4 = 4'h3; ci4 = 1'b0; v4 = 1'b1; ordy4 = 1'b1;
        step();
        v4 = 1'b0;
        n_tests++; if (ov4 !== 1'b0)    begin n_fail++; $display("FAIL lat_early: got ov %b want 0", ov4); end
        step();
        n_tests++; if (ov4 !== 1'b1)    begin n_fail++; $display("FAIL lat_valid: got ov %b want 1", ov4); end
        n_tests++; if (s4 !== 4'hD)     begin n_fail++; $display("FAIL lat_sum: got %h want D", s4); end
        n_tests++; if (co4 !== 1'b0)    begin n_fail++; $display("FAIL lat_co: got %b want 0", co4); end
        step();
        n_tests++; if (ov4 !== 1'b0)    begin n_fail++; $display("FAIL lat_dup: got ov %b want 0", ov4); end
    endtask

    task automatic test_wrap();
        n_tests++; if (cnt4 !== 16'd0)  begin n_fail++; $display("FAIL wrap_cnt_pre: got %0d want 0", cnt4); end
        a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1; v4 = 1'b1;
        step();
        v4 = 1'b0;
        step();
        n_tests++; if (ov4 !== 1'b1)    begin n_fail++; $display("FAIL wrap_valid: got %b want 1", ov4); end
        n_tests++; if (s4 !== 4'h0)     begin n_fail++; $display("FAIL wrap_sum: got %h want 0", s4); end
        n_tests++; if (co4 !== 1'b1)    begin n_fail++; $display("FAIL wrap_co: got %b want 1", co4); end
        step();
        n_tests++; if (cnt4 !== 16'd1)  begin n_fail++; $display("FAIL wrap_cnt_post: got %0d want 1", cnt4); end
    endtask

    // Back-to-back vectors on u4 with carries crossing the slice boundary.
    task automatic test_back_to_back();
        logic [3:0] va [5] = '{4'h7, 4'h5, 4'hF, 4'h2, 4'h8};
        logic [3:0] vb [5] = '{4'h9, 4'h6, 4'hF, 4'h1, 4'h8};
        logic       vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] es [5] = '{4'h0, 4'hC, 4'hF, 4'h3, 4'h0};
        logic       ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int got = 0;
        ordy4 = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 5) begin
                a4 = va[cyc]; b4 = vb[cyc]; ci4 = vc[cyc]; v4 = 1'b1;
            end else begin
                v4 = 1'b0;
            end
            @(negedge clk);
            if (ov4) begin
                if (got < 5) begin
                    n_tests++; if (s4 !== es[got] || co4 !== ec[got]) begin
                        n_fail++; $display("FAIL b2b_%0d: got co=%b sum=%h want co=%b sum=%h", got, co4, s4, ec[got], es[got]);
                    end
                    // Results must arrive one per cycle, starting two cycles after the first push.
                    n_tests++; if (cyc !== got + 2) begin
                        n_fail++; $display("FAIL b2b_slot_%0d: got cycle %0d want %0d", got, cyc, got + 2);
                    end
                end
                got++;
            end
            step();
        end
        n_tests++; if (got !== 5)       begin n_fail++; $display("FAIL b2b_count: got %0d want 5", got); end
        n_tests++; if (cnt4 !== 16'd4)  begin n_fail++; $display("FAIL b2b_ovf: got %0d want 4", cnt4); end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got  = 0;
        logic [8:0] e;
        b8 = 8'h01; ci8 = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 256; cyc++) begin
            v8    = (sent < 256);
            a8    = sent[7:0];
            ordy8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++; if (r8 !== (!ov8 || ordy8)) begin
                n_fail++; $display("FAIL stream_rdy c%0d: got %b want %b", cyc, r8, (!ov8 || ordy8));
            end
            if (ov8 && ordy8) begin
                e = 9'(got + 1);
                n_tests++; if (s8 !== e[7:0] || co8 !== e[8]) begin
                    n_fail++; $display("FAIL stream_%0d: got co=%b sum=%h want co=%b sum=%h", got, co8, s8, e[8], e[7:0]);
                end
                got++;
            end
            if (v8 && r8) sent++;
            step();
        end
        v8 = 1'b0; ordy8 = 1'b1;
        n_tests++; if (got !== 256)     begin n_fail++; $display("FAIL stream_count: got %0d want 256", got); end
        n_tests++; if (cnt8 !== 16'd1)  begin n_fail++; $display("FAIL stream_ovf: got %0d want 1", cnt8); end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got  = 0;
        ordy8 = 1'b0; b8 = 8'h20; ci8 = 1'b0;
        for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
            a8 = 8'h10 + 8'(sent); v8 = 1'b1;
            @(negedge clk);
            if (v8 && r8) sent++;
            step();
        end
        // Keep offering a value that must not be accepted while stalled.
        a8 = 8'h99; v8 = 1'b1;
        n_tests++; if (sent !== 4)      begin n_fail++; $display("FAIL stall_fill: got %0d want 4", sent); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (r8 !== 1'b0 || ov8 !== 1'b1 || s8 !== 8'h30 || co8 !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold_%0d: got rdy=%b ov=%b co=%b sum=%h want rdy=0 ov=1 co=0 sum=30", i, r8, ov8, co8, s8);
            end
            step();
        end
        v8 = 1'b0; ordy8 = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            if (ov8) begin
                n_tests++; if (s8 !== 8'h30 + 8'(got) || co8 !== 1'b0) begin
                    n_fail++; $display("FAIL stall_drain_%0d: got co=%b sum=%h want co=0 sum=%h", got, co8, s8, 8'h30 + 8'(got));
                end
                got++;
            end
            step();
        end
        n_tests++; if (got !== 4)       begin n_fail++; $display("FAIL stall_count: got %0d want 4", got); end
        repeat (3) step();
        n_tests++; if (ov8 !== 1'b0)    begin n_fail++; $display("FAIL stall_extra: got ov %b want 0", ov8); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s_v;
        logic c_v;
        bit ok;
        bit stale = 1'b0;
        ordy8 = 1'b1;
        put8(8'hFF, 8'h01, 1'b0);
        put8(8'hFF, 8'h01, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (ov8 !== 1'b0)    begin n_fail++; $display("FAIL rmid_ov: got %b want 0", ov8); end
        n_tests++; if (cnt8 !== 16'd0)  begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", cnt8); end
        n_tests++; if (s8 !== 8'h00 || co8 !== 1'b0) begin
            n_fail++; $display("FAIL rmid_data: got co=%b sum=%h want co=0 sum=00", co8, s8);
        end
        n_tests++; if (r8 !== 1'b1)     begin n_fail++; $display("FAIL rmid_rdy: got %b want 1", r8); end
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov8) stale = 1'b1;
            step();
        end
        n_tests++; if (stale !== 1'b0)  begin n_fail++; $display("FAIL rmid_stale: got ov seen %b want 0", stale); end
        put8(8'h01, 8'h02, 1'b0);
        get8(s_v, c_v, ok);
        n_tests++; if (!ok)             begin n_fail++; $display("FAIL rmid_timeout: got no result want one"); end
        n_tests++; if (s_v !== 8'h03 || c_v !== 1'b0) begin
            n_fail++; $display("FAIL rmid_fresh: got co=%b sum=%h want co=0 sum=03", c_v, s_v);
        end
        n_tests++; if (cnt8 !== 16'd0)  begin n_fail++; $display("FAIL rmid_cnt_post: got %0d want 0", cnt8); end
    endtask

`ifdef ADDER_PIPE_SAT_EN
    task automatic test_sat();
        logic [7:0] s_v;
        logic c_v;
        bit ok;
        sat8 = 1'b1;
        put8(8'hF0, 8'h20, 1'b0);
        sat8 = 1'b0;
        get8(s_v, c_v, ok);
        n_tests++; if (!ok || s_v !== 8'hFF || c_v !== 1'b1) begin
            n_fail++; $display("FAIL sat_on: got ok=%b co=%b sum=%h want ok=1 co=1 sum=FF", ok, c_v, s_v);
        end
        put8(8'hF0, 8'h20, 1'b0);
        get8(s_v, c_v, ok);
        n_tests++; if (!ok || s_v !== 8'h10 || c_v !== 1'b1) begin
            n_fail++; $display("FAIL sat_off: got ok=%b co=%b sum=%h want ok=1 co=1 sum=10", ok, c_v, s_v);
        end
        n_tests++; if (cnt8 !== 16'd2)  begin n_fail++; $display("FAIL sat_ovf: got %0d want 2", cnt8); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_stream();
        test_stall();
        test_reset_mid();
`ifdef ADDER_PIPE_SAT_EN
        test_sat();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
